pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset (`RST = 1'b0), sampled on rising clk.
REQ-003 jump_flag  input  1  EX-stage taken branch/jump request.
REQ-004 jump_addr  input  `INST_ADDR_WIDTH  EX-stage target address.
REQ-005 id_rs1_raddr, id_rs2_raddr  input  `REG_ADDR_WIDTH  ID-stage source register addresses.
REQ-006 id_rs1_re, id_rs2_re  input  1 each  ID-stage source read enables.
REQ-007 ex_rd_waddr  input  `REG_ADDR_WIDTH  destination register of the instruction in EX.
REQ-008 ex_mem_rd  input  1  instruction in EX is a load.
REQ-009 mem_req  input  1  data-bus request from EX/MEM; mem_ack  input  1  data-bus ready.
REQ-010 hold_pc, hold_if, hold_id  output  1 each  hold to PC, IF/ID and ID/EX registers; asserted value `HOLD.
REQ-011 flush_if, flush_id  output  1 each  bubble insertion into IF/ID and ID/EX; active high.
REQ-012 jump_o  output  1; jump_addr_o  output  `INST_ADDR_WIDTH  redirect to PC.
REQ-013 bus_err  output  1  one-cycle bus-timeout pulse.
REQ-014 stall_cnt  output  32  count of cycles with hold_pc asserted.

Function
REQ-015 FSM states: IDLE, MEM_WAIT, JUMP_FLUSH; reset state IDLE.
REQ-016 Priority, highest first: bus wait, jump, load-use hazard.
REQ-017 Bus wait: in IDLE with mem_req=1 and mem_ack=0, hold_pc/hold_if/hold_id asserted combinationally in the same cycle; next state MEM_WAIT.
REQ-018 MEM_WAIT: all three holds asserted; flush_*, jump_o = 0; jump_flag ignored (EX is frozen, so the request persists).
REQ-019 MEM_WAIT exit: when mem_ack=1, holds deasserted in that same cycle; next state IDLE.
REQ-020 Timeout: 4-bit wait counter cleared on MEM_WAIT entry, +1 per MEM_WAIT cycle without ack; on the 16th MEM_WAIT cycle without ack: bus_err=1 for that cycle, holds deasserted, next state IDLE.
REQ-021 Jump: in IDLE with jump_flag=1 and no bus wait: jump_o=1, jump_addr_o=jump_addr, flush_if=1, flush_id=1 in the same cycle; next state JUMP_FLUSH.
REQ-022 JUMP_FLUSH: flush_if=1 for exactly one cycle (covers the synchronous fetch latency); flush_id=0; jump_o=0; next state IDLE.
REQ-023 A new jump_flag in JUMP_FLUSH is honoured per REQ-021 (re-enters JUMP_FLUSH).
REQ-024 Load-use: in IDLE or JUMP_FLUSH, with no bus wait and no jump: ex_mem_rd=1, ex_rd_waddr≠0, and (id_rs1_re and id_rs1_raddr=ex_rd_waddr) or (id_rs2_re and id_rs2_raddr=ex_rd_waddr) -> hold_pc=hold_if=`HOLD, flush_id=1, hold_id deasserted, for that cycle only; no state change.
REQ-025 Register x0 never creates a hazard.
REQ-026 jump_addr_o = 0 whenever jump_o = 0.
REQ-027 stall_cnt increments by 1 in each cycle in which hold_pc is asserted and saturates at 32'hFFFF_FFFF.
REQ-028 All non-asserted holds are driven to ~`HOLD; there are no X outputs after reset.

Reset
REQ-029 With rst=0 at a clock edge: state=IDLE, wait counter=0, stall_cnt=0.
REQ-030 During and after reset, while inputs are idle: holds=~`HOLD; flush_if, flush_id, jump_o, bus_err=0; jump_addr_o=0.
REQ-031 Reset asserted mid-MEM_WAIT or mid-JUMP_FLUSH aborts the operation; no bus_err pulse is generated.

Verification
REQ-032 Load-use: ex_mem_rd=1, ex_rd_waddr=5, id_rs1_re=1, id_rs1_raddr=5 for 1 cycle -> hold_pc=hold_if=`HOLD, flush_id=1 for 1 cycle; stall_cnt 0->1; the same case with ex_rd_waddr=0 gives no stall.
REQ-033 Jump: jump_flag=1, jump_addr=32'h100 for 1 cycle -> jump_o=1, jump_addr_o=32'h100, flush_if=flush_id=1 in that cycle; next cycle flush_if=1 only; then all 0.
REQ-034 Bus wait: mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1 -> holds asserted for 3 cycles, released in the ack cycle; stall_cnt=3.
REQ-035 Timeout: mem_req=1, mem_ack=0 held -> holds for 16 cycles, bus_err=1 on the 16th MEM_WAIT cycle, state IDLE afterwards.
REQ-036 Simultaneous events: mem_req=1/mem_ack=0 with jump_flag=1 and a load-use hit -> only holds asserted; jump taken in the cycle after mem_ack.
REQ-037 Reset mid-MEM_WAIT: rst=0 on the 5th wait cycle -> next cycle all outputs at reset values, bus_err never pulses.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Control and handshake bundle between the pipeline and the
//               hazard/flush controller (pipe_ctrl).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH  = 5
);
  // EX-stage redirect request
  logic                       jump_flag;
  logic [INST_ADDR_WIDTH-1:0] jump_addr;
  // ID-stage source operands
  logic [REG_ADDR_WIDTH-1:0]  id_rs1_raddr;
  logic [REG_ADDR_WIDTH-1:0]  id_rs2_raddr;
  logic                       id_rs1_re;
  logic                       id_rs2_re;
  // EX-stage destination
  logic [REG_ADDR_WIDTH-1:0]  ex_rd_waddr;
  logic                       ex_mem_rd;
  // Data-bus handshake
  logic                       mem_req;
  logic                       mem_ack;
  // Controller outputs
  logic                       hold_pc;
  logic                       hold_if;
  logic                       hold_id;
  logic                       flush_if;
  logic                       flush_id;
  logic                       jump_o;
  logic [INST_ADDR_WIDTH-1:0] jump_addr_o;
  logic                       bus_err;
  logic [31:0]                stall_cnt;

  // Pipeline side: drives requests, receives controls
  modport master (
    output jump_flag, jump_addr, id_rs1_raddr, id_rs2_raddr, id_rs1_re,
           id_rs2_re, ex_rd_waddr, ex_mem_rd, mem_req, mem_ack,
    input  hold_pc, hold_if, hold_id, flush_if, flush_id, jump_o,
           jump_addr_o, bus_err, stall_cnt
  );

  // Controller side
  modport slave (
    input  jump_flag, jump_addr, id_rs1_raddr, id_rs2_raddr, id_rs1_re,
           id_rs2_re, ex_rd_waddr, ex_mem_rd, mem_req, mem_ack,
    output hold_pc, hold_if, hold_id, flush_if, flush_id, jump_o,
           jump_addr_o, bus_err, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller. Arbitrates data-bus wait, taken
//               jumps and load-use hazards into hold/flush controls, flags a
//               bus timeout and counts stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic HOLD = 1'b1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_MEM_WAIT   = 2'd1,
    S_JUMP_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0]  c_WAIT_LAST = 4'hF;
  localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_stall_cnt;

  logic w_bus_wait;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_hold_pc;
  logic w_hold_if;
  logic w_hold_id;
  logic w_flush_if;
  logic w_flush_id;
  logic w_jump;
  logic w_bus_err;

  // Hazard detection; x0 is never a real producer so it is excluded
  assign w_bus_wait = bus.mem_req & ~bus.mem_ack;
  assign w_rs1_hit  = bus.id_rs1_re & (bus.id_rs1_raddr == bus.ex_rd_waddr);
  assign w_rs2_hit  = bus.id_rs2_re & (bus.id_rs2_raddr == bus.ex_rd_waddr);
  assign w_load_use = bus.ex_mem_rd & (bus.ex_rd_waddr != '0) &
                      (w_rs1_hit | w_rs2_hit);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and control decode: bus wait beats jump beats load-use
  always_comb begin
    w_next     = r_state;
    w_hold_pc  = 1'b0;
    w_hold_if  = 1'b0;
    w_hold_id  = 1'b0;
    w_flush_if = 1'b0;
    w_flush_id = 1'b0;
    w_jump     = 1'b0;
    w_bus_err  = 1'b0;
    case (r_state)
      S_IDLE, S_JUMP_FLUSH: begin
        if (w_bus_wait) begin
          w_hold_pc = 1'b1;
          w_hold_if = 1'b1;
          w_hold_id = 1'b1;
          w_next    = S_MEM_WAIT;
        end else if (bus.jump_flag) begin
          w_jump     = 1'b1;
          w_flush_if = 1'b1;
          w_flush_id = 1'b1;
          w_next     = S_JUMP_FLUSH;
        end else begin
          // Second bubble covers the instruction already in flight from fetch
          w_flush_if = (r_state == S_JUMP_FLUSH);
          w_next     = S_IDLE;
          if (w_load_use) begin
            w_hold_pc  = 1'b1;
            w_hold_if  = 1'b1;
            w_flush_id = 1'b1;
          end
        end
      end
      S_MEM_WAIT: begin
        // EX is frozen here, so a pending jump is simply re-seen after release
        if (bus.mem_ack) begin
          w_next = S_IDLE;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_bus_err = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_hold_pc = 1'b1;
          w_hold_if = 1'b1;
          w_hold_id = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Wait counter: zero outside MEM_WAIT so it starts cleared on entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state != S_MEM_WAIT) begin
      r_wait_cnt <= 4'd0;
    end else if (!bus.mem_ack) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_hold_pc && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Outputs are forced quiet while reset is low so an aborted wait never
  // leaks a hold or bus_err pulse
  assign bus.hold_pc     = (rst & w_hold_pc) ? HOLD : ~HOLD;
  assign bus.hold_if     = (rst & w_hold_if) ? HOLD : ~HOLD;
  assign bus.hold_id     = (rst & w_hold_id) ? HOLD : ~HOLD;
  assign bus.flush_if    = rst & w_flush_if;
  assign bus.flush_id    = rst & w_flush_id;
  assign bus.jump_o      = rst & w_jump;
  assign bus.jump_addr_o = (rst & w_jump) ? bus.jump_addr : '0;
  assign bus.bus_err     = rst & w_bus_err;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
